// File: rtl/qysys_test_pio_pkg.sv
// Shared constants for the Qsys test PIO slaves: s1 register map and
// edge-capture mode encodings.
package qysys_test_pio_pkg;

    // s1 word addresses
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // Capture edge selection
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/qysys_test_bit_sync.sv
// Multi-bit synchroniser for an asynchronous input bus. Every bit gets its own
// SYNC_STAGES-deep flop chain; bits are not treated as a coherent word.
module qysys_test_bit_sync #(
    parameter int unsigned WIDTH       = 14,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    // Shift the raw input through the chain; stage 0 is the metastable catcher.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/qysys_test_datain_capture.sv
// Avalon-MM s1 input PIO: synchronised read of in_port, sticky per-bit edge
// capture (write-1-to-clear) and a maskable level interrupt.
module qysys_test_datain_capture
    import qysys_test_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 14,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rd_sel;
    logic             wr_en;
    logic             wr_mask;
    logic             wr_edge;
    logic             unused_wdata;

    qysys_test_bit_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (cur)
    );

    // Bits of writedata above WIDTH have no home.
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    assign wr_en   = chipselect & ~write_n;
    assign wr_mask = wr_en && (address == ADDR_MASK);
    assign wr_edge = wr_en && (address == ADDR_EDGE);

    // Previous synchronised sample for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= cur;
        end
    end

    // Per-bit edge detect selected by the build-time capture mode.
    always_comb begin
        det = cur & ~prev_q;
        if (EDGE_TYPE == EDGE_FALL) begin
            det = ~cur & prev_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            det = cur ^ prev_q;
        end
    end

    // Next-state for MASK and EDGE; a fresh detect beats a same-cycle clear.
    always_comb begin
        mask_d   = wr_mask ? wdata : mask_q;
        edge_clr = wr_edge ? wdata : '0;
        edge_d   = (edge_q & ~edge_clr) | det;
    end

    // MASK and EDGE capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= RESET_MASK;
            edge_q <= '0;
        end else begin
            mask_q <= mask_d;
            edge_q <= edge_d;
        end
    end

    // Level interrupt straight from the registers.
    assign irq = |(edge_q & mask_q);

    // Zero-wait read mux, zero-extended to the bus width.
    always_comb begin
        rd_sel = '0;
        unique case (address)
            ADDR_DATA: rd_sel = cur;
            ADDR_RSVD: rd_sel = '0;
            ADDR_MASK: rd_sel = mask_q;
            ADDR_EDGE: rd_sel = edge_q;
            default:   rd_sel = '0;
        endcase
        readdata              = '0;
        readdata[WIDTH-1:0]   = rd_sel;
    end

endmodule
